// File: rtl/h14tx_pkg.sv
// rtl/h14tx_pkg.sv - shared TMDS/TERC4 types, code table and decode helper
//
// Purpose: the single TERC4 code table used by both the encoder and the
//          decoder. Also holds the lock-state enum and the reverse lookup
//          function terc4_decode.
// Contents:
//   symbol_t        10-bit TMDS symbol
//   data_t          4-bit TERC4 payload nibble
//   lock_state_e    SEARCH / LOCKED
//   TERC4_CODES     nibble -> symbol table, indexed by nibble value
//   TERC4_GUARD_DI  data-island guard-band symbol
//   terc4_decode    symbol -> {hit, nibble}
package h14tx_pkg;

  typedef logic [9:0] symbol_t;
  typedef logic [3:0] data_t;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam symbol_t TERC4_CODES [16] = '{
    10'b1010011100,  // 0000
    10'b1001100011,  // 0001
    10'b1011100100,  // 0010
    10'b1011100010,  // 0011
    10'b0101110001,  // 0100
    10'b0100011110,  // 0101
    10'b0110001110,  // 0110
    10'b0100111100,  // 0111
    10'b1011001100,  // 1000
    10'b0100111001,  // 1001
    10'b0110011100,  // 1010
    10'b1011000110,  // 1011
    10'b1010001110,  // 1100
    10'b1001110001,  // 1101
    10'b0101100011,  // 1110
    10'b1011000011   // 1111
  };

  localparam symbol_t TERC4_GUARD_DI = 10'b0100110011;

  // Reverse lookup. Bit 4 is the hit flag and bits 3:0 are the nibble.
  // On a miss the nibble is 0, and the caller ignores it.
  function automatic logic [4:0] terc4_decode(input symbol_t sym);
    logic [4:0] res;
    res = 5'b0;
    for (int i = 0; i < 16; i++) begin
      if (sym == TERC4_CODES[i]) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/h14tx_decoding_terc4.sv
// rtl/h14tx_decoding_terc4.sv - TERC4 symbol decoder with lock tracking for one TMDS channel
//
// Purpose: decodes aligned 10-bit TMDS symbols back to TERC4 nibbles one
//          clock after input. It flags illegal codes, keeps a saturating
//          illegal-symbol count, and runs a SEARCH/LOCKED state machine.
// Optional: define H14TX_TERC4_GUARD_DETECT_EN to add the guard output. The
//           data-island guard-band code then raises guard instead of being
//           treated as an illegal code.
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous reset, active low
//   symbol        in   aligned TMDS symbol
//   symbol_valid  in   symbol qualifies this cycle
//   data          out  decoded nibble; holds when no legal decode occurs
//   data_valid    out  data is a legal decode of a qualified symbol
//   code_err      out  qualified symbol is not a TERC4 code
//   locked        out  state machine is in LOCKED
//   guard         out  (optional) qualified symbol was the guard-band code
//   err_count     out  saturating count of code_err pulses
module h14tx_decoding_terc4
  import h14tx_pkg::*;
#(
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  symbol_t              symbol,
  input  logic                 symbol_valid,
  output data_t                data,
  output logic                 data_valid,
  output logic                 code_err,
  output logic                 locked,
`ifdef H14TX_TERC4_GUARD_DETECT_EN
  output logic                 guard,
`endif
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [7:0] LOCK_CNT8   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_CNT8 = 8'(UNLOCK_ERRS);

  logic [4:0] w_dec;
  logic       w_hit;
  data_t      w_nibble;
  logic       w_is_guard;

  lock_state_e          r_state;
  logic [7:0]           r_good_run;
  logic [7:0]           r_bad_run;
  data_t                r_data;
  logic                 r_data_valid;
  logic                 r_code_err;
  logic                 r_locked;
  logic [ERR_CNT_W-1:0] r_err_count;

  always_comb begin
    w_dec    = terc4_decode(symbol);
    w_hit    = w_dec[4];
    w_nibble = w_dec[3:0];
  end

`ifdef H14TX_TERC4_GUARD_DETECT_EN
  logic r_guard;
  assign w_is_guard = (symbol == TERC4_GUARD_DI);
  assign guard      = r_guard;
`else
  assign w_is_guard = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= SEARCH;
      r_good_run   <= 8'd0;
      r_bad_run    <= 8'd0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_code_err   <= 1'b0;
      r_locked     <= 1'b0;
      r_err_count  <= '0;
`ifdef H14TX_TERC4_GUARD_DETECT_EN
      r_guard      <= 1'b0;
`endif
    end else begin
      // Strobes are one-cycle pulses. Idle cycles leave the run counters
      // and the state unchanged.
      r_data_valid <= 1'b0;
      r_code_err   <= 1'b0;
`ifdef H14TX_TERC4_GUARD_DETECT_EN
      r_guard      <= 1'b0;
`endif
      if (symbol_valid) begin
        if (w_is_guard) begin
          // The guard band does not affect decoding or lock tracking.
`ifdef H14TX_TERC4_GUARD_DETECT_EN
          r_guard <= 1'b1;
`endif
        end else if (w_hit) begin
          r_data       <= w_nibble;
          r_data_valid <= 1'b1;
          if (r_state == SEARCH) begin
            if (r_good_run + 8'd1 >= LOCK_CNT8) begin
              // Lock in the same cycle as this symbol's data_valid.
              r_state    <= LOCKED;
              r_locked   <= 1'b1;
              r_good_run <= LOCK_CNT8;
              r_bad_run  <= 8'd0;
            end else begin
              r_good_run <= r_good_run + 8'd1;
            end
          end else begin
            r_bad_run <= 8'd0;
          end
        end else begin
          r_code_err <= 1'b1;
          if (r_err_count != {ERR_CNT_W{1'b1}}) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
          end
          if (r_state == SEARCH) begin
            r_good_run <= 8'd0;
          end else if (r_bad_run + 8'd1 >= UNLOCK_CNT8) begin
            r_state    <= SEARCH;
            r_locked   <= 1'b0;
            r_good_run <= 8'd0;
            r_bad_run  <= 8'd0;
          end else begin
            r_bad_run <= r_bad_run + 8'd1;
          end
        end
      end
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign code_err   = r_code_err;
  assign locked     = r_locked;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_h14tx_decoding_terc4.sv
// tb/tb_h14tx_decoding_terc4.sv - scoreboard testbench for h14tx_decoding_terc4
module tb_h14tx_decoding_terc4;

  localparam int LOCK_N   = 8;
  localparam int UNLOCK_N = 4;
  localparam int ERR_W    = 4;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [9:0]       symbol;
  logic             symbol_valid;
  logic [3:0]       data;
  logic             data_valid;
  logic             code_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;
`ifdef H14TX_TERC4_GUARD_DETECT_EN
  logic             guard;
`endif

  h14tx_decoding_terc4 #(
    .LOCK_COUNT (LOCK_N),
    .UNLOCK_ERRS(UNLOCK_N),
    .ERR_CNT_W  (ERR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .symbol      (symbol),
    .symbol_valid(symbol_valid),
    .data        (data),
    .data_valid  (data_valid),
    .code_err    (code_err),
    .locked      (locked),
`ifdef H14TX_TERC4_GUARD_DETECT_EN
    .guard       (guard),
`endif
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  logic [9:0] tbl [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  localparam logic [9:0] GUARD_SYM = 10'b0100110011;

  typedef struct {
    int data;
    int dv;
    int ce;
    int lk;
    int err;
    int g;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state, written only by the driver.
  int m_data = 0, m_lk = 0, m_good = 0, m_bad = 0, m_err = 0;

  function automatic int lookup(input logic [9:0] s);
    for (int i = 0; i < 16; i++) if (tbl[i] == s) return i;
    return -1;
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endfunction

  task automatic drive(input bit rst, input bit v, input logic [9:0] s);
    exp_t e;
    int   idx;
    bit   is_guard;
    @(negedge clk);
    rst_n        = rst;
    symbol_valid = v;
    symbol       = s;
    e.dv = 0; e.ce = 0; e.g = 0;
`ifdef H14TX_TERC4_GUARD_DETECT_EN
    is_guard = (s == GUARD_SYM);
`else
    is_guard = 1'b0;
`endif
    idx = lookup(s);
    if (!rst) begin
      m_data = 0; m_lk = 0; m_good = 0; m_bad = 0; m_err = 0;
    end else if (v) begin
      if (is_guard) begin
        e.g = 1;
      end else if (idx >= 0) begin
        m_data = idx;
        e.dv = 1;
        if (!m_lk) begin
          m_good++;
          if (m_good >= LOCK_N) begin m_lk = 1; m_bad = 0; end
        end else begin
          m_bad = 0;
        end
      end else begin
        e.ce = 1;
        if (m_err < ERR_MAX) m_err++;
        if (!m_lk) m_good = 0;
        else begin
          m_bad++;
          if (m_bad >= UNLOCK_N) begin m_lk = 0; m_good = 0; m_bad = 0; end
        end
      end
    end
    e.data = m_data; e.lk = m_lk; e.err = m_err;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each registered output against the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data", int'(data), e.data);
        chk("data_valid", int'(data_valid), e.dv);
        chk("code_err", int'(code_err), e.ce);
        chk("locked", int'(locked), e.lk);
        chk("err_count", int'(err_count), e.err);
`ifdef H14TX_TERC4_GUARD_DETECT_EN
        chk("guard", int'(guard), e.g);
`endif
      end
    end
  end

  function automatic logic [9:0] rand_sym();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 60) return tbl[$urandom_range(0, 15)];
    if (r < 85) return 10'($urandom);
    if (r < 92) return GUARD_SYM;
    return 10'b0;
  endfunction

  initial begin
    rst_n = 1'b0; symbol_valid = 1'b0; symbol = '0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    // Round trip of all 16 codes.
    for (int i = 0; i < 16; i++) drive(1, 1, tbl[i]);
    // Lock entry after an interrupted run.
    drive(0, 0, 0);
    for (int i = 0; i < 7; i++) drive(1, 1, tbl[i]);
    drive(1, 1, 10'b0);
    for (int i = 0; i < 8; i++) drive(1, 1, tbl[15 - i]);
    // Unlock: 3 bad, 1 good, 4 bad.
    for (int i = 0; i < 3; i++) drive(1, 1, 10'b0);
    drive(1, 1, tbl[5]);
    for (int i = 0; i < 4; i++) drive(1, 1, 10'b1111111111);
    // Error-count saturation.
    for (int i = 0; i < 20; i++) drive(1, 1, 10'b0);
    // Idle gaps in SEARCH, then a one-cycle reset mid-run.
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, tbl[i]);
      drive(1, 0, tbl[i + 1]);
    end
    drive(0, 1, tbl[3]);
    for (int i = 0; i < 10; i++) drive(1, 1, tbl[i]);
`ifdef H14TX_TERC4_GUARD_DETECT_EN
    // Guard band while locked.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, GUARD_SYM);
      drive(1, 1, tbl[i]);
    end
`endif
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 85), rand_sym());
    end
    drive(1, 0, 0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
